// File: rtl/regfile_pkg.sv
// Shared lock-state encoding and wrap-around issue-id age comparison
// for the scoreboard register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    FREE,
    PENDING,
    COMMITTED
  } lock_state_e;

  localparam int unsigned ID_MAX_WIDTH = 32;

  // a is older than b when the modular difference has its top id bit set
  function automatic logic id_older(input logic [ID_MAX_WIDTH-1:0] a,
                                    input logic [ID_MAX_WIDTH-1:0] b,
                                    input int unsigned              width);
    logic [ID_MAX_WIDTH-1:0] diff;
    diff = a - b;
    return (a != b) && diff[width-1];
  endfunction

endpackage

// File: rtl/reg_lock_slot.sv
// One physical register: data, lock state, owner, write arbitration among
// its requesters, read eligibility and commit bypass.
module reg_lock_slot
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 12,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 port_hit,
  input  logic [NUM_PORTS-1:0]                 port_req_read,
  input  logic [NUM_PORTS-1:0]                 port_req_write,
  input  logic [NUM_PORTS-1:0]                 port_commit,
  input  logic [NUM_PORTS-1:0]                 port_rel,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   port_issue_id,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]                 grant,
  output logic [NUM_PORTS-1:0]                 cmd_err,
  output logic [DATA_WIDTH-1:0]                read_value
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  lock_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [ID_WIDTH-1:0]   owner_id_q, owner_id_d;

  logic                  wr_any;
  logic [PW-1:0]         win_idx;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  owner_commit, owner_rel;
  logic                  read_ok, write_ok;

  function automatic logic older(input logic [ID_WIDTH-1:0] a,
                                 input logic [ID_WIDTH-1:0] b);
    return id_older(ID_MAX_WIDTH'(a), ID_MAX_WIDTH'(b), ID_WIDTH);
  endfunction

  always_comb begin
    wr_any  = 1'b0;
    win_idx = '0;
    win_id  = '0;
    // Strictly-older replaces the running winner, so ties keep the lowest port
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (port_hit[p] && port_req_write[p]) begin
        if (!wr_any || older(port_issue_id[p], win_id)) begin
          wr_any  = 1'b1;
          win_idx = PW'(p);
          win_id  = port_issue_id[p];
        end
      end
    end

    owner_commit = port_hit[owner_q] && port_commit[owner_q] && (state_q != FREE);
    owner_rel    = port_hit[owner_q] && port_rel[owner_q] && (state_q != FREE);
    read_value   = (state_q == PENDING) ? port_wdata[owner_q] : data_q;

    grant    = '0;
    cmd_err  = '0;
    read_ok  = 1'b0;
    write_ok = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      read_ok = 1'b0;
      unique case (state_q)
        FREE: begin
          read_ok = 1'b1;
          for (int unsigned q = 0; q < NUM_PORTS; q++) begin
            if (port_hit[q] && port_req_write[q] && older(port_issue_id[q], port_issue_id[p]))
              read_ok = 1'b0;
          end
        end
        PENDING:   read_ok = owner_commit && older(owner_id_q, port_issue_id[p]);
        COMMITTED: read_ok = older(owner_id_q, port_issue_id[p]);
        default:   read_ok = 1'b0;
      endcase
      write_ok = (state_q == FREE) && wr_any && (win_idx == PW'(p));
      if (port_hit[p] && (port_req_read[p] || port_req_write[p]))
        grant[p] = (!port_req_read[p] || read_ok) && (!port_req_write[p] || write_ok);
      cmd_err[p] = port_hit[p] && (port_commit[p] || port_rel[p]) &&
                   ((state_q == FREE) || (owner_q != PW'(p)));
    end

    state_d    = state_q;
    data_d     = data_q;
    owner_d    = owner_q;
    owner_id_d = owner_id_q;
    if (state_q == FREE) begin
      if (wr_any && grant[win_idx]) begin
        state_d    = PENDING;
        owner_d    = win_idx;
        owner_id_d = win_id;
      end
    end else begin
      if (owner_commit) begin
        data_d  = port_wdata[owner_q];
        state_d = COMMITTED;
      end
      if (owner_rel)
        state_d = FREE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      data_q     <= '0;
      owner_q    <= '0;
      owner_id_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      owner_q    <= owner_d;
      owner_id_q <= owner_id_d;
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Scoreboarded register file: decodes each port's address to a lock slot
// and muxes the slot's grant, error and read data back to the port.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int NUM_PHY_REGS = 32,
  parameter int TOTAL_PORTS  = 12,
  parameter int ID_WIDTH     = 6,
  parameter int DATA_WIDTH   = 32,
  localparam int AW          = $clog2(NUM_PHY_REGS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [TOTAL_PORTS-1:0][AW-1:0]         port_addr,
  input  logic [TOTAL_PORTS-1:0]                 port_req_read,
  input  logic [TOTAL_PORTS-1:0]                 port_req_write,
  input  logic [TOTAL_PORTS-1:0]                 port_write_commit,
  input  logic [TOTAL_PORTS-1:0]                 port_release,
  input  logic [TOTAL_PORTS-1:0][ID_WIDTH-1:0]   port_issue_id,
  input  logic [TOTAL_PORTS-1:0][DATA_WIDTH-1:0] port_wdata,
  output logic [TOTAL_PORTS-1:0]                 port_grant_out,
  output logic [TOTAL_PORTS-1:0][DATA_WIDTH-1:0] port_rdata_out,
  output logic [TOTAL_PORTS-1:0]                 port_err_out
);

  logic [NUM_PHY_REGS-1:0][TOTAL_PORTS-1:0] slot_hit, slot_grant, slot_err;
  logic [NUM_PHY_REGS-1:0][DATA_WIDTH-1:0]  slot_value;

  for (genvar r = 0; r < NUM_PHY_REGS; r++) begin : gen_slot
    for (genvar p = 0; p < TOTAL_PORTS; p++) begin : gen_hit
      assign slot_hit[r][p] = (port_addr[p] == AW'(r));
    end

    reg_lock_slot #(
      .NUM_PORTS  (TOTAL_PORTS),
      .ID_WIDTH   (ID_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk            (clk),
      .rst            (rst),
      .port_hit       (slot_hit[r]),
      .port_req_read  (port_req_read),
      .port_req_write (port_req_write),
      .port_commit    (port_write_commit),
      .port_rel       (port_release),
      .port_issue_id  (port_issue_id),
      .port_wdata     (port_wdata),
      .grant          (slot_grant[r]),
      .cmd_err        (slot_err[r]),
      .read_value     (slot_value[r])
    );
  end

  logic                  addr_ok, sel_grant, sel_err;
  logic [DATA_WIDTH-1:0] sel_value;

  // An address matching no slot is out of range; its requests reach no slot
  always_comb begin
    port_grant_out = '0;
    port_err_out   = '0;
    port_rdata_out = '0;
    addr_ok        = 1'b0;
    sel_grant      = 1'b0;
    sel_err        = 1'b0;
    sel_value      = '0;
    for (int unsigned p = 0; p < TOTAL_PORTS; p++) begin
      addr_ok   = 1'b0;
      sel_grant = 1'b0;
      sel_err   = 1'b0;
      sel_value = '0;
      for (int unsigned r = 0; r < NUM_PHY_REGS; r++) begin
        if (slot_hit[r][p]) begin
          addr_ok   = 1'b1;
          sel_grant = slot_grant[r][p];
          sel_err   = slot_err[r][p];
          sel_value = slot_value[r];
        end
      end
      if (!rst) begin
        port_grant_out[p] = sel_grant;
        port_err_out[p]   = sel_err || (!addr_ok && (port_req_read[p] || port_req_write[p] ||
                                                     port_write_commit[p] || port_release[p]));
        port_rdata_out[p] = (sel_grant && port_req_read[p]) ? sel_value : '0;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench for scoreboard_regfile: directed vector table, a reset
// mid-lock sequence, and randomized traffic against an abstract lock model.
module tb_scoreboard_regfile;

  localparam int NREG = 32;
  localparam int NP   = 12;
  localparam int IDW  = 6;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0]          rd, wr, cm, rl;
  logic [NP-1:0][IDW-1:0] id;
  logic [NP-1:0][DW-1:0]  wd;
  logic [NP-1:0]          grant, err;
  logic [NP-1:0][DW-1:0]  rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scoreboard_regfile #(
    .NUM_PHY_REGS (NREG),
    .TOTAL_PORTS  (NP),
    .ID_WIDTH     (IDW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .port_addr         (addr),
    .port_req_read     (rd),
    .port_req_write    (wr),
    .port_write_commit (cm),
    .port_release      (rl),
    .port_issue_id     (id),
    .port_wdata        (wd),
    .port_grant_out    (grant),
    .port_rdata_out    (rdata),
    .port_err_out      (err)
  );

  typedef struct {
    int          port;
    int          a;
    bit          r, w, c, l;
    int          iid;
    logic [31:0] d;
  } op_t;

  typedef struct {
    string         name;
    op_t           o0, o1, o2;
    logic [NP-1:0] eg, ee;
    int            cp;
    logic [31:0]   ed;
  } vec_t;

  vec_t vt[16];

  // Reference lock model: 0 free, 1 pending, 2 committed
  int          st[NREG];
  logic [31:0] md[NREG];
  int          own[NREG];
  int          oid[NREG];

  function automatic op_t mk(int port, int a, bit r, bit w, bit c, bit l, int iid, logic [31:0] d);
    op_t o;
    o.port = port; o.a = a; o.r = r; o.w = w; o.c = c; o.l = l; o.iid = iid; o.d = d;
    return o;
  endfunction

  function automatic op_t nop();
    return mk(-1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mv(string name, op_t o0, op_t o1, op_t o2,
                              logic [NP-1:0] eg, logic [NP-1:0] ee, int cp, logic [31:0] ed);
    vec_t v;
    v.name = name; v.o0 = o0; v.o1 = o1; v.o2 = o2;
    v.eg = eg; v.ee = ee; v.cp = cp; v.ed = ed;
    return v;
  endfunction

  function automatic bit older(int a, int b);
    return (a != b) && (((a - b + 64) % 64) >= 32);
  endfunction

  task automatic clear_in();
    addr = '0; rd = '0; wr = '0; cm = '0; rl = '0; id = '0; wd = '0;
  endtask

  task automatic apply_op(input op_t o);
    if (o.port >= 0) begin
      addr[o.port] = AW'(o.a);
      rd[o.port]   = o.r;
      wr[o.port]   = o.w;
      cm[o.port]   = o.c;
      rl[o.port]   = o.l;
      id[o.port]   = IDW'(o.iid);
      wd[o.port]   = o.d;
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NREG; a++) begin
      st[a] = 0; md[a] = '0; own[a] = 0; oid[a] = 0;
    end
  endtask

  task automatic model_eval(output logic [NP-1:0] eg, output logic [NP-1:0] ee,
                            output logic [NP-1:0][DW-1:0] ed);
    eg = '0; ee = '0; ed = '0;
    for (int p = 0; p < NP; p++) begin
      int a;
      bit rok, wok, g;
      a   = int'(addr[p]);
      rok = 0;
      wok = 0;
      if (st[a] == 0) begin
        rok = 1;
        wok = 1;
        for (int q = 0; q < NP; q++) begin
          if (int'(addr[q]) == a && wr[q]) begin
            if (older(int'(id[q]), int'(id[p]))) rok = 0;
            if (q != p && (older(int'(id[q]), int'(id[p])) || (id[q] == id[p] && q < p))) wok = 0;
          end
        end
      end else if (st[a] == 1) begin
        rok = (int'(addr[own[a]]) == a) && cm[own[a]] && older(oid[a], int'(id[p]));
      end else begin
        rok = older(oid[a], int'(id[p]));
      end
      g     = (rd[p] || wr[p]) && (!rd[p] || rok) && (!wr[p] || wok);
      eg[p] = g;
      ee[p] = (cm[p] || rl[p]) && (st[a] == 0 || own[a] != p);
      if (g && rd[p]) ed[p] = (st[a] == 1) ? wd[own[a]] : md[a];
    end
  endtask

  task automatic model_update(input logic [NP-1:0] eg);
    for (int a = 0; a < NREG; a++) begin
      if (st[a] == 0) begin
        for (int p = 0; p < NP; p++) begin
          if (int'(addr[p]) == a && wr[p] && eg[p]) begin
            st[a] = 1; own[a] = p; oid[a] = int'(id[p]);
          end
        end
      end else begin
        int o;
        o = own[a];
        if (int'(addr[o]) == a && cm[o]) begin
          md[a] = wd[o]; st[a] = 2;
        end
        if (int'(addr[o]) == a && rl[o]) st[a] = 0;
      end
    end
  endtask

  task automatic randomize_in(input int base);
    for (int p = 0; p < NP; p++) begin
      addr[p] = AW'($urandom_range(0, 3));
      rd[p]   = ($urandom_range(0, 2) == 0);
      wr[p]   = ($urandom_range(0, 3) == 0);
      cm[p]   = ($urandom_range(0, 3) == 0);
      rl[p]   = ($urandom_range(0, 5) == 0);
      id[p]   = IDW'((base + int'($urandom_range(0, 15))) % 64);
      wd[p]   = $urandom();
    end
  endtask

  initial begin
    logic [NP-1:0]         eg, ee;
    logic [NP-1:0][DW-1:0] ed;
    int                    base;

    vt[0]  = mv("wr_arb",       mk(0, 5, 0, 1, 0, 0, 9, 0), mk(1, 5, 0, 1, 0, 0, 7, 0), nop(), 12'h002, 12'h000, 1, 32'h0);
    vt[1]  = mv("bypass",       mk(1, 5, 0, 0, 1, 0, 7, 32'hDEAD_BEEF), mk(2, 5, 1, 0, 0, 0, 10, 0), nop(), 12'h004, 12'h000, 2, 32'hDEAD_BEEF);
    vt[2]  = mv("old_reader",   mk(2, 5, 1, 0, 0, 0, 5, 0), mk(4, 5, 1, 0, 0, 0, 7, 0), nop(), 12'h000, 12'h000, 2, 32'h0);
    vt[3]  = mv("multi_read",   mk(2, 5, 1, 0, 0, 0, 8, 0), mk(3, 5, 1, 0, 0, 0, 20, 0), nop(), 12'h00C, 12'h000, 3, 32'hDEAD_BEEF);
    vt[4]  = mv("nonowner_rel", mk(3, 5, 0, 0, 0, 1, 0, 0), nop(), nop(), 12'h000, 12'h008, 3, 32'h0);
    vt[5]  = mv("still_locked", mk(6, 5, 0, 1, 0, 0, 30, 0), mk(2, 5, 1, 0, 0, 0, 9, 0), nop(), 12'h004, 12'h000, 2, 32'hDEAD_BEEF);
    vt[6]  = mv("owner_rel",    mk(1, 5, 0, 0, 0, 1, 7, 0), nop(), nop(), 12'h000, 12'h000, 1, 32'h0);
    vt[7]  = mv("free_read",    mk(2, 5, 1, 0, 0, 0, 0, 0), nop(), nop(), 12'h004, 12'h000, 2, 32'hDEAD_BEEF);
    vt[8]  = mv("wrap_r3",      mk(0, 3, 0, 1, 0, 0, 62, 0), mk(1, 3, 1, 0, 0, 0, 1, 0), nop(), 12'h001, 12'h000, 1, 32'h0);
    vt[9]  = mv("pend_noread",  mk(1, 3, 1, 0, 0, 0, 1, 0), mk(5, 3, 0, 0, 1, 0, 1, 32'h1111), nop(), 12'h000, 12'h020, 1, 32'h0);
    vt[10] = mv("commit_free",  mk(4, 9, 0, 0, 1, 0, 0, 32'h2222), nop(), nop(), 12'h000, 12'h010, 4, 32'h0);
    vt[11] = mv("commit_rel",   mk(0, 3, 0, 0, 1, 1, 62, 32'h55AA), mk(1, 3, 1, 0, 0, 0, 1, 0), nop(), 12'h002, 12'h000, 1, 32'h55AA);
    vt[12] = mv("after_rel",    mk(2, 3, 1, 0, 0, 0, 40, 0), mk(3, 3, 0, 1, 0, 0, 45, 0), nop(), 12'h00C, 12'h000, 2, 32'h55AA);
    vt[13] = mv("rw_same_port", mk(4, 10, 1, 1, 0, 0, 20, 0), mk(5, 10, 0, 1, 0, 0, 18, 0), nop(), 12'h020, 12'h000, 4, 32'h0);
    vt[14] = mv("tie_low_idx",  mk(6, 11, 0, 1, 0, 0, 3, 0), mk(7, 11, 0, 1, 0, 0, 3, 0), nop(), 12'h040, 12'h000, 6, 32'h0);
    vt[15] = mv("rw_both_ok",   mk(8, 12, 1, 1, 0, 0, 4, 0), nop(), nop(), 12'h100, 12'h000, 8, 32'h0);

    // Reset with busy inputs: every output held low
    rst = 1'b1;
    randomize_in(0);
    rd = '1; wr = '1;
    #3;
    chk("rst_grant", DW'(grant), '0);
    chk("rst_err", DW'(err), '0);
    chk("rst_rdata0", rdata[0], '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_in();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear_in();
      apply_op(vt[i].o0);
      apply_op(vt[i].o1);
      apply_op(vt[i].o2);
      #2;
      chk({vt[i].name, "_grant"}, DW'(grant), DW'(vt[i].eg));
      chk({vt[i].name, "_err"}, DW'(err), DW'(vt[i].ee));
      chk({vt[i].name, "_rdata"}, rdata[vt[i].cp], vt[i].ed);
    end

    // Reset while r7 is committed and its owner is committing again
    @(negedge clk);
    clear_in();
    apply_op(mk(0, 7, 0, 1, 0, 0, 1, 0));
    #2;
    chk("r7_lock", DW'(grant), DW'(12'h001));
    @(negedge clk);
    clear_in();
    apply_op(mk(0, 7, 0, 0, 1, 0, 1, 32'h1234));
    #2;
    chk("r7_commit_err", DW'(err), '0);
    @(negedge clk);
    clear_in();
    apply_op(mk(0, 7, 0, 0, 1, 0, 1, 32'h9999));
    apply_op(mk(1, 7, 1, 0, 0, 0, 2, 0));
    #1;
    chk("r7_pre_rst_rdata", rdata[1], 32'h1234);
    rst = 1'b1;
    #1;
    chk("r7_rst_grant", DW'(grant), '0);
    chk("r7_rst_err", DW'(err), '0);
    chk("r7_rst_rdata", rdata[1], '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    apply_op(mk(1, 7, 1, 0, 0, 0, 2, 0));
    apply_op(mk(0, 7, 0, 0, 0, 1, 1, 0));
    #2;
    chk("r7_free_grant", DW'(grant), DW'(12'h002));
    chk("r7_free_err", DW'(err), DW'(12'h001));
    chk("r7_free_rdata", rdata[1], '0);

    // Randomized traffic on a small register window against the model
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    base = 60;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (cyc % 50 == 49) base = (base + 5) % 64;
      randomize_in(base);
      for (int a = 0; a < 4; a++) begin
        if (st[a] != 0 && $urandom_range(0, 1) == 1) begin
          addr[own[a]] = AW'(a);
          cm[own[a]]   = ($urandom_range(0, 3) != 0);
          rl[own[a]]   = ($urandom_range(0, 3) == 0);
        end
      end
      #2;
      model_eval(eg, ee, ed);
      chk("rand_grant", DW'(grant), DW'(eg));
      chk("rand_err", DW'(err), DW'(ee));
      for (int p = 0; p < NP; p++) chk("rand_rdata", rdata[p], ed[p]);
      model_update(eg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter NUM_PHY_REGS, default 32, number of physical registers.
REQ-002 SHALL have parameter TOTAL_PORTS, default 12, number of access ports.
REQ-003 SHALL have parameter ID_WIDTH, default 6, issue-id width; ids compare by wrap-around age.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port port_addr  input  [TOTAL_PORTS] x clog2(NUM_PHY_REGS)  target register per port.
REQ-008 SHALL have port port_req_read  input  [TOTAL_PORTS] x 1  read request.
REQ-009 SHALL have port port_req_write  input  [TOTAL_PORTS] x 1  write-lock request.
REQ-010 SHALL have port port_write_commit  input  [TOTAL_PORTS] x 1  write data to the locked register this cycle.
REQ-011 SHALL have port port_release  input  [TOTAL_PORTS] x 1  drop the lock held by this port.
REQ-012 SHALL have port port_issue_id  input  [TOTAL_PORTS] x ID_WIDTH  issue id of the requesting instruction.
REQ-013 SHALL have port port_wdata  input  [TOTAL_PORTS] x DATA_WIDTH  commit data.
REQ-014 SHALL have port port_grant_out  output  [TOTAL_PORTS] x 1  request granted this cycle.
REQ-015 SHALL have port port_rdata_out  output  [TOTAL_PORTS] x DATA_WIDTH  read data, valid when read granted.
REQ-016 SHALL have port port_err_out  output  [TOTAL_PORTS] x 1  illegal access this cycle.

Function
REQ-017 Each register SHALL hold data, lock state {FREE, PENDING, COMMITTED}, owner port index and owner issue id.
REQ-018 Id a SHALL be older than b iff a != b and bit ID_WIDTH-1 of (a - b) mod 2^ID_WIDTH is 1.
REQ-019 Grants, rdata and err SHALL be combinational same-cycle; state changes SHALL take effect at the next edge.
REQ-020 Write grant: register FREE; among its write requesters the oldest id wins, ties to lowest port index; only one winner per register.
REQ-021 On write grant, the register SHALL become PENDING with owner = winning port and id at the next edge.
REQ-022 Read grant in FREE: only if no write requester to the same register this cycle is older than the reader; data = stored value.
REQ-023 Read grant in PENDING: only if the owner port commits this cycle and reader id is younger than owner; data = owner's port_wdata (bypass).
REQ-024 Read grant in COMMITTED: reader id younger than owner; data = stored value.
REQ-025 A reader older than or equal to the owner id SHALL never be granted while the register is locked.
REQ-026 Commit from the owner port SHALL write port_wdata and move PENDING->COMMITTED; a repeat commit in COMMITTED overwrites.
REQ-027 Release from the owner port SHALL move the register to FREE; commit+release same cycle writes data then frees.
REQ-028 Write request and read request on one port SHALL grant only if both conditions hold.
REQ-029 port_err_out SHALL be 1 for address >= NUM_PHY_REGS, or commit/release from a non-owner, or to a FREE register; such requests SHALL be ignored.
REQ-030 port_rdata_out SHALL be 0 when the port has no read grant.
REQ-031 Multiple readers of one register SHALL all be granted in the same cycle when eligible.

Reset
REQ-032 While rst is 1, all registers SHALL be FREE with data 0, owner 0.
REQ-033 While rst is 1, all grants, err and rdata outputs SHALL be 0 regardless of inputs.
REQ-034 Reset mid-lock SHALL discard the lock and any same-cycle commit.

Structure
REQ-035 Package regfile_pkg SHALL hold lock_state_e and the id age-compare function.
REQ-036 One sub-module reg_lock_slot SHALL implement the per-register state, arbitration and bypass; the top does routing and output muxing.

Verification
REQ-037 Ports 0,1 write-request r5 with ids 9,7 -> port 1 granted, r5 PENDING owner 1 next cycle.
REQ-038 Port 1 commits 0xDEAD_BEEF to r5 while port 2 (id 10) reads -> port 2 granted same cycle with rdata 0xDEAD_BEEF.
REQ-039 Ids wrap: writer id 62 and reader id 1 (ID_WIDTH 6) on FREE r3 -> reader not granted, writer granted.
REQ-040 Port 3 releases r5 owned by port 1 -> port_err_out[3]=1, r5 state unchanged; owner release -> FREE.
REQ-041 Assert rst while r7 COMMITTED and commit in flight -> r7 FREE, data 0, all outputs 0.
